spi_minion_array: RTL and testbench

Parametrised multi-channel SPI minion front-end that generalises the team's two-channel SPI minion interface to NCH independent channels of configurable word width. Each channel synchronises its own cs/sclk/mosi pins into the system clock domain, runs a full-duplex SPI mode-0 shift engine, and buffers received words in a DEPTH-entry FIFO. Each channel also holds one queued transmit word and keeps sticky overflow, underflow and framing-error flags. The block sits between the user-project GPIO pins and the FFT datapath, exposing val/rdy streams on the core side.

---
 rtl/spi_minion_array.sv | 170 +++++++++++++++++
 tb/tb_spi_minion_array.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_minion_array.sv
// NCH independent SPI mode-0 minion channels: pin synchronisers, full-duplex shift
// engine, one-word TX holding register, FWFT RX FIFO and sticky error flags per channel.
module spi_minion_array #(
   parameter int unsigned NCH   = 2,
   parameter int unsigned NBITS = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       cs,
   input  logic [NCH-1:0]       sclk,
   input  logic [NCH-1:0]       mosi,
   output logic [NCH-1:0]       miso,
   output logic [NCH-1:0]       miso_oeb,
   output logic [NCH*NBITS-1:0] recv_msg,
   output logic [NCH-1:0]       recv_val,
   input  logic [NCH-1:0]       recv_rdy,
   input  logic [NCH*NBITS-1:0] send_msg,
   input  logic [NCH-1:0]       send_val,
   output logic [NCH-1:0]       send_rdy,
   output logic [NCH-1:0]       err_ovf,
   output logic [NCH-1:0]       err_unf,
   output logic [NCH-1:0]       err_frm,
   input  logic [NCH-1:0]       err_clr
);

   localparam int unsigned CW = $clog2(NBITS + 2);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [2:0]       cs_q, sclk_q, mosi_q;
      logic [1:0]       fill_q, fill_d;
      logic             armed_q, armed_d;
      state_t           state_q, state_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic [NBITS-1:0] rx_q, rx_d, tx_q, tx_d, hold_q, hold_d;
      logic             txf_q, txf_d;
      logic             ovf_q, ovf_d, unf_q, unf_d, frm_q, frm_d;
      logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
      logic [NBITS-1:0] mem_q [DEPTH];
      logic             push, pop, fifo_full, fifo_empty, load;
      logic             cs_fall, cs_rise, sck_rise, sck_fall;

      always_ff @(posedge clk) begin
         if (reset) begin
            cs_q   <= '1;
            sclk_q <= '0;
            mosi_q <= '0;
         end else begin
            cs_q   <= {cs_q[1:0], cs[g]};
            sclk_q <= {sclk_q[1:0], sclk[g]};
            mosi_q <= {mosi_q[1:0], mosi[g]};
         end
      end

      // The sync chain holds reset values for two cycles; arming waits until
      // cs_q[1] reflects the real pin so a cs held low through reset is ignored.
      assign cs_fall  = armed_q & cs_q[2] & ~cs_q[1];
      assign cs_rise  = ~cs_q[2] & cs_q[1];
      assign sck_rise = sclk_q[1] & ~sclk_q[2];
      assign sck_fall = ~sclk_q[1] & sclk_q[2];

      assign fifo_empty = (wp_q == rp_q);
      assign fifo_full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
      assign pop        = ~fifo_empty & recv_rdy[g];
      assign load       = send_val[g] & ~txf_q;

      always_comb begin
         fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
         armed_d = armed_q | ((fill_q == 2'd2) & cs_q[1]);
         state_d = state_q;
         cnt_d   = cnt_q;
         rx_d    = rx_q;
         tx_d    = tx_q;
         hold_d  = hold_q;
         txf_d   = txf_q;
         ovf_d   = ovf_q & ~err_clr[g];
         unf_d   = unf_q & ~err_clr[g];
         frm_d   = frm_q & ~err_clr[g];
         push    = 1'b0;
         if (load) begin
            hold_d = send_msg[g*NBITS +: NBITS];
            txf_d  = 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = '0;
                  if (txf_q) begin
                     tx_d  = hold_q;
                     txf_d = 1'b0;
                  end else begin
                     tx_d  = '0;
                     unf_d = 1'b1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state_d = ST_IDLE;
                  if (cnt_q == CW'(NBITS)) begin
                     if (!fifo_full || pop) push  = 1'b1;
                     else                   ovf_d = 1'b1;
                  end else begin
                     frm_d = 1'b1;
                  end
               end else begin
                  if (sck_rise) begin
                     rx_d = {rx_q[NBITS-2:0], mosi_q[2]};
                     if (cnt_q != CW'(NBITS + 1)) cnt_d = cnt_q + 1'b1;
                  end
                  if (sck_fall) tx_d = {tx_q[NBITS-2:0], 1'b0};
               end
            end
            default: state_d = ST_IDLE;
         endcase
         wp_d = push ? wp_q + 1'b1 : wp_q;
         rp_d = pop  ? rp_q + 1'b1 : rp_q;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            fill_q  <= '0;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            hold_q  <= '0;
            txf_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            frm_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
         end else begin
            fill_q  <= fill_d;
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            hold_q  <= hold_d;
            txf_q   <= txf_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            frm_q   <= frm_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
         end
      end

      always_ff @(posedge clk) begin
         if (push) mem_q[wp_q[AW-1:0]] <= rx_q;
      end

      assign miso[g]                       = (state_q == ST_ACTIVE) ? tx_q[NBITS-1] : 1'b0;
      assign miso_oeb[g]                   = (state_q != ST_ACTIVE);
      assign recv_msg[g*NBITS +: NBITS]    = mem_q[rp_q[AW-1:0]];
      assign recv_val[g]                   = ~fifo_empty;
      assign send_rdy[g]                   = ~txf_q;
      assign err_ovf[g]                    = ovf_q;
      assign err_unf[g]                    = unf_q;
      assign err_frm[g]                    = frm_q;
   end

endmodule

// File: tb/tb_spi_minion_array.sv
// Randomised bench for spi_minion_array: a master bit-bangs the pins and a
// queue-based transaction model predicts FIFO contents, MISO stream and flags.
module tb_spi_minion_array;
   localparam int NCH   = 2;
   localparam int NBITS = 32;
   localparam int DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NCH-1:0]       cs, sclk, mosi, miso, miso_oeb;
   logic [NCH*NBITS-1:0] recv_msg, send_msg;
   logic [NCH-1:0]       recv_val, recv_rdy, send_val, send_rdy;
   logic [NCH-1:0]       err_ovf, err_unf, err_frm, err_clr;

   int total = 0;
   int bad   = 0;

   logic [NBITS-1:0] mq [NCH][$];
   logic             m_txf  [NCH];
   logic [NBITS-1:0] m_hold [NCH];
   logic             m_ovf [NCH], m_unf [NCH], m_frm [NCH];

   spi_minion_array #(.NCH(NCH), .NBITS(NBITS), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
      .miso(miso), .miso_oeb(miso_oeb), .recv_msg(recv_msg), .recv_val(recv_val),
      .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
      .err_ovf(err_ovf), .err_unf(err_unf), .err_frm(err_frm), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         mq[c].delete();
         m_txf[c]  = 1'b0;
         m_hold[c] = '0;
         m_ovf[c]  = 1'b0;
         m_unf[c]  = 1'b0;
         m_frm[c]  = 1'b0;
      end
   endtask

   task automatic check_ch(input int ch, input string tag);
      check($sformatf("%s/val%0d", tag, ch), recv_val[ch], mq[ch].size() != 0);
      if (mq[ch].size() != 0)
         check($sformatf("%s/msg%0d", tag, ch), recv_msg[ch*NBITS +: NBITS], mq[ch][0]);
      check($sformatf("%s/rdy%0d", tag, ch), send_rdy[ch], !m_txf[ch]);
      check($sformatf("%s/ovf%0d", tag, ch), err_ovf[ch], m_ovf[ch]);
      check($sformatf("%s/unf%0d", tag, ch), err_unf[ch], m_unf[ch]);
      check($sformatf("%s/frm%0d", tag, ch), err_frm[ch], m_frm[ch]);
      check($sformatf("%s/oeb%0d", tag, ch), miso_oeb[ch], 1'b1);
      check($sformatf("%s/miso%0d", tag, ch), miso[ch], 1'b0);
   endtask

   task automatic clock_bits(input int ch, input logic [NBITS-1:0] w, input int from,
                             input int upto, output logic [63:0] cap);
      cap = '0;
      for (int i = from; i < upto; i++) begin
         mosi[ch] = (i < NBITS) ? w[NBITS-1-i] : 1'($urandom_range(0, 1));
         tick(5);
         cap = {cap[62:0], miso[ch]};
         sclk[ch] = 1'b1;
         tick(5);
         sclk[ch] = 1'b0;
      end
   endtask

   task automatic do_frame(input int ch, input logic [NBITS-1:0] w, input int nbits,
                           input string tag);
      logic [NBITS-1:0] txw;
      logic [63:0]      cap, exp;
      txw = m_txf[ch] ? m_hold[ch] : '0;
      if (!m_txf[ch]) m_unf[ch] = 1'b1;
      m_txf[ch] = 1'b0;
      exp = {txw, 32'h0} >> (64 - nbits);
      cs[ch] = 1'b0;
      tick(8);
      check($sformatf("%s/act_oeb%0d", tag, ch), miso_oeb[ch], 1'b0);
      check($sformatf("%s/act_rdy%0d", tag, ch), send_rdy[ch], 1'b1);
      clock_bits(ch, w, 0, nbits, cap);
      tick(5);
      cs[ch]   = 1'b1;
      mosi[ch] = 1'b0;
      tick(6);
      check($sformatf("%s/miso_word%0d", tag, ch), cap, exp);
      if (nbits == NBITS) begin
         if (mq[ch].size() < DEPTH) mq[ch].push_back(w);
         else                       m_ovf[ch] = 1'b1;
      end else begin
         m_frm[ch] = 1'b1;
      end
      check_ch(ch, tag);
   endtask

   task automatic send(input int ch, input logic [NBITS-1:0] w);
      check($sformatf("send/rdy%0d", ch), send_rdy[ch], 1'b1);
      send_msg[ch*NBITS +: NBITS] = w;
      send_val[ch] = 1'b1;
      tick(1);
      send_val[ch] = 1'b0;
      m_txf[ch]  = 1'b1;
      m_hold[ch] = w;
      check_ch(ch, "send");
   endtask

   task automatic pop(input int ch);
      check_ch(ch, "prepop");
      recv_rdy[ch] = 1'b1;
      tick(1);
      recv_rdy[ch] = 1'b0;
      if (mq[ch].size() != 0) void'(mq[ch].pop_front());
      check_ch(ch, "pop");
   endtask

   task automatic clr(input int ch);
      err_clr[ch] = 1'b1;
      tick(1);
      err_clr[ch] = 1'b0;
      m_ovf[ch] = 1'b0;
      m_unf[ch] = 1'b0;
      m_frm[ch] = 1'b0;
      check_ch(ch, "clr");
   endtask

   initial begin
      logic [63:0]      cap;
      logic [NBITS-1:0] w;
      int               ch, op, r, nb;
      cs = '1; sclk = '0; mosi = '0;
      send_msg = '0; send_val = '0; recv_rdy = '0; err_clr = '0;
      reset = 1'b1;
      model_reset();
      tick(3);
      reset = 1'b0;
      tick(4);
      for (int c = 0; c < NCH; c++) check_ch(c, "reset");

      // Basic frame on channel 0
      send(0, 32'hA5A5_0F0F);
      do_frame(0, 32'h1234_5678, NBITS, "basic");
      pop(0);

      // Concurrent channels with skewed phase
      send(0, 32'h0BAD_F00D);
      send(1, 32'h5555_AAAA);
      fork
         do_frame(0, 32'hDEAD_BEEF, NBITS, "conc");
         begin tick(7); do_frame(1, 32'hCAFE_F00D, NBITS, "conc"); end
      join
      pop(0);
      pop(1);

      // Overflow on channel 1
      for (int k = 0; k < DEPTH + 1; k++) do_frame(1, $urandom, NBITS, "ovf");
      clr(1);
      for (int k = 0; k < DEPTH; k++) pop(1);

      // Underflow: no TX word queued
      do_frame(0, $urandom, NBITS, "unf");
      pop(0);
      clr(0);

      // Framing error, then a normal frame
      send(0, $urandom);
      do_frame(0, $urandom, NBITS - 1, "frm");
      send(0, $urandom);
      do_frame(0, $urandom, NBITS, "after_frm");
      pop(0);
      clr(0);

      // Reset mid-transaction with cs held low
      send(0, $urandom);
      w = $urandom;
      cs[0] = 1'b0;
      tick(8);
      clock_bits(0, w, 0, 10, cap);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      model_reset();
      tick(4);
      check_ch(0, "midrst");
      clock_bits(0, w, 10, NBITS, cap);
      tick(5);
      cs[0] = 1'b1;
      tick(6);
      check_ch(0, "midrst_tail");
      check_ch(1, "midrst_tail");
      do_frame(0, $urandom, NBITS, "post_rst");
      pop(0);
      clr(0);

      // Randomised operation mix
      repeat (30) begin
         ch = $urandom_range(0, NCH - 1);
         op = $urandom_range(0, 9);
         if (op <= 1 && !m_txf[ch]) begin
            send(ch, $urandom);
         end else if (op <= 6) begin
            r  = $urandom_range(0, 7);
            nb = (r < 5) ? NBITS : (r == 5) ? NBITS - 1 : (r == 6) ? NBITS + 1
                 : $urandom_range(2, NBITS - 2);
            do_frame(ch, $urandom, nb, "rnd");
         end else if (op <= 8) begin
            pop(ch);
         end else begin
            clr(ch);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
